// File: rtl/bsn_pkg.sv
// rtl/bsn_pkg.sv - shared types, constants and seed helper for the stochastic bitstream network
// Contents:
//   VALUE_W   - width of every operand, weight and integrated count
//   LFSR_TAPS - feedback mask for x^8+x^6+x^5+x^4+1 (Fibonacci, shift-left form)
//   state_t   - controller states
//   seed_of   - per-generator seed, never zero

package bsn_pkg;

    localparam int VALUE_W = 8;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Map base+idx into 1..255 so no generator ever starts in the LFSR lock-up state.
    function automatic logic [7:0] seed_of(input logic [7:0] base, input int idx);
        int s;
        s = ((int'(base) + idx) % 255) + 1;
        return 8'(s);
    endfunction

endpackage

// File: rtl/bsn_generator.sv
// rtl/bsn_generator.sv - one stochastic bitstream source: reseedable LFSR plus comparator
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   load     - reload the LFSR with SEED_VAL
//   step     - advance the LFSR one state
//   value    - probability operand, x represents x/255
//   stream   - current stream bit, high when lfsr <= value

module bsn_generator
    import bsn_pkg::*;
#(
    parameter logic [7:0] SEED_VAL = 8'h01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [VALUE_W-1:0] value,
    output logic               stream
);

    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED_VAL;
        end else if (load) begin
            lfsr <= SEED_VAL;
        end else if (step) begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    // The LFSR visits 1..255, so value 0 never fires and value 255 always fires.
    assign stream = (lfsr <= value);

endmodule

// File: rtl/bsn_network.sv
// rtl/bsn_network.sv - parametrised stochastic bitstream network with writable weights and run handshake
// Ports:
//   clk, rst                                   - clock, asynchronous active-high reset
//   wr_en, wr_layer, wr_neuron, wr_input,
//   wr_data                                    - weight write port, honoured in IDLE only
//   in_valid, in_ready, in_data                - operand vector handshake, 8 bits per channel
//   out_valid, out_ready, out_data             - integrated result handshake, 8 bits per output
//   busy                                       - high while loading or running

module bsn_network
    import bsn_pkg::*;
#(
    parameter int         INPUT_SIZE  = 2,
    parameter int         HIDDEN_SIZE = 2,
    parameter int         OUTPUT_SIZE = 1,
    parameter int         STREAM_LEN  = 255,
    parameter logic [7:0] SEED        = 8'h6A
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic                             wr_layer,
    input  logic [3:0]                       wr_neuron,
    input  logic [3:0]                       wr_input,
    input  logic [VALUE_W-1:0]               wr_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [VALUE_W*INPUT_SIZE-1:0]    in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [VALUE_W*OUTPUT_SIZE-1:0]   out_data,
    output logic                             busy
);

    localparam int NW1  = HIDDEN_SIZE * INPUT_SIZE;
    localparam int NW2  = OUTPUT_SIZE * HIDDEN_SIZE;
    localparam int G_W1 = INPUT_SIZE;
    localparam int G_W2 = INPUT_SIZE + NW1;

    state_t state, state_nxt;

    logic [VALUE_W*INPUT_SIZE-1:0] in_lat;
    logic [VALUE_W-1:0]            w1 [NW1];
    logic [VALUE_W-1:0]            w2 [NW2];
    logic [VALUE_W-1:0]            integ [OUTPUT_SIZE];
    logic [3:0]                    sel1;
    logic [3:0]                    sel2;
    logic [7:0]                    cyc_cnt;

    logic [INPUT_SIZE-1:0]  in_bits;
    logic [NW1-1:0]         w1_bits;
    logic [NW2-1:0]         w2_bits;
    logic [HIDDEN_SIZE-1:0] hid;
    logic [OUTPUT_SIZE-1:0] obit;

    logic gen_load;
    logic gen_step;
    logic last_cycle;

    assign gen_load   = (state == LOAD);
    assign gen_step   = (state == RUN);
    assign last_cycle = (state == RUN) && (cyc_cnt == 8'(STREAM_LEN - 1));

    // Generator index order: inputs, then layer-1 weights, then layer-2 weights (neuron-major).
    genvar g;
    for (g = 0; g < INPUT_SIZE; g++) begin : g_in
        bsn_generator #(.SEED_VAL(seed_of(SEED, g))) u_gen (
            .clk    (clk),
            .rst    (rst),
            .load   (gen_load),
            .step   (gen_step),
            .value  (in_lat[VALUE_W*g +: VALUE_W]),
            .stream (in_bits[g])
        );
    end

    for (g = 0; g < NW1; g++) begin : g_w1
        bsn_generator #(.SEED_VAL(seed_of(SEED, G_W1 + g))) u_gen (
            .clk    (clk),
            .rst    (rst),
            .load   (gen_load),
            .step   (gen_step),
            .value  (w1[g]),
            .stream (w1_bits[g])
        );
    end

    for (g = 0; g < NW2; g++) begin : g_w2
        bsn_generator #(.SEED_VAL(seed_of(SEED, G_W2 + g))) u_gen (
            .clk    (clk),
            .rst    (rst),
            .load   (gen_load),
            .step   (gen_step),
            .value  (w2[g]),
            .stream (w2_bits[g])
        );
    end

    // Neurons: AND each input stream with its weight stream, then pick one product per
    // cycle with the layer's shared round-robin select. Averaged over the window this is
    // the (1/N)-scaled dot product.
    always_comb begin
        hid = '0;
        for (int n = 0; n < HIDDEN_SIZE; n++) begin
            for (int k = 0; k < INPUT_SIZE; k++) begin
                if (sel1 == 4'(k)) begin
                    hid[n] = in_bits[k] & w1_bits[n*INPUT_SIZE + k];
                end
            end
        end
        obit = '0;
        for (int m = 0; m < OUTPUT_SIZE; m++) begin
            for (int j = 0; j < HIDDEN_SIZE; j++) begin
                if (sel2 == 4'(j)) begin
                    obit[m] = hid[j] & w2_bits[m*HIDDEN_SIZE + j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN:  if (last_cycle) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        busy      = (state == LOAD) || (state == RUN);
        out_valid = (state == DONE);
    end

    // Weight storage; indices outside the configured sizes simply match no entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NW1; i++) w1[i] <= '0;
            for (int i = 0; i < NW2; i++) w2[i] <= '0;
        end else if (state == IDLE && wr_en) begin
            for (int n = 0; n < HIDDEN_SIZE; n++) begin
                for (int k = 0; k < INPUT_SIZE; k++) begin
                    if (!wr_layer && wr_neuron == 4'(n) && wr_input == 4'(k)) begin
                        w1[n*INPUT_SIZE + k] <= wr_data;
                    end
                end
            end
            for (int m = 0; m < OUTPUT_SIZE; m++) begin
                for (int j = 0; j < HIDDEN_SIZE; j++) begin
                    if (wr_layer && wr_neuron == 4'(m) && wr_input == 4'(j)) begin
                        w2[m*HIDDEN_SIZE + j] <= wr_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_lat   <= '0;
            sel1     <= '0;
            sel2     <= '0;
            cyc_cnt  <= '0;
            out_data <= '0;
            for (int m = 0; m < OUTPUT_SIZE; m++) integ[m] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) in_lat <= in_data;
                end
                LOAD: begin
                    sel1    <= '0;
                    sel2    <= '0;
                    cyc_cnt <= '0;
                    for (int m = 0; m < OUTPUT_SIZE; m++) integ[m] <= '0;
                end
                RUN: begin
                    sel1    <= (sel1 == 4'(INPUT_SIZE - 1))  ? 4'd0 : sel1 + 4'd1;
                    sel2    <= (sel2 == 4'(HIDDEN_SIZE - 1)) ? 4'd0 : sel2 + 4'd1;
                    cyc_cnt <= cyc_cnt + 8'd1;
                    for (int m = 0; m < OUTPUT_SIZE; m++) begin
                        integ[m] <= integ[m] + 8'(obit[m]);
                        // The final bit is folded in directly so the result lands with DONE.
                        if (last_cycle) begin
                            out_data[VALUE_W*m +: VALUE_W] <= integ[m] + 8'(obit[m]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bsn_network.md
Name: bsn_network

Overview:
- Parametrised successor of the fixed 2-2-1 stochastic bitstream network, with configurable input, hidden and output widths.
- Adds runtime-writable weights, a run/ready/valid handshake, and a deterministic, reseeded evaluation window so repeated runs give identical results.
- Sits between a host register interface and the application, which streams operand vectors in and collects integrated results.

Parameters:
- INPUT_SIZE, 2, network inputs; 1..16.
- HIDDEN_SIZE, 2, hidden-layer neurons; 1..16.
- OUTPUT_SIZE, 1, output neurons; 1..16.
- STREAM_LEN, 255, RUN cycles per evaluation; 1..255.
- SEED, 8'h6A, base LFSR seed.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  weight write strobe.
- wr_layer  in  1  0 = layer 1, 1 = layer 2.
- wr_neuron  in  4  neuron index.
- wr_input  in  4  input index within the neuron.
- wr_data  in  8  weight value.
- in_valid  in  1  input vector valid.
- in_ready  out  1  high in IDLE only.
- in_data  in  8*INPUT_SIZE  unsigned inputs; channel k is bits [8k+7:8k].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_data  out  8*OUTPUT_SIZE  integrated counts, same packing as in_data.
- busy  out  1  high in LOAD or RUN.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; all weights = 0; in_data latch = 0.
  - out_data = 0; out_valid = 0; busy = 0; in_ready = 0 while rst is high.
  - Reset mid-run aborts immediately; no partial result is emitted.
- Value encoding: 8-bit unsigned x represents probability x/255.
- Generator: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, period 255, states 1..255.
  - Output bit = (lfsr <= x). So x=0 gives always 0, x=255 gives always 1.
- Seeds: generator index g gets seed ((SEED+g) mod 255)+1. Seeds are never 0.
  - Index order: inputs 0..INPUT_SIZE-1.
  - Then layer-1 weights, neuron-major (n*INPUT_SIZE + k).
  - Then layer-2 weights, same order.
- Neuron:
  - Product_k = input_bit_k AND weight_bit_k.
  - Output bit = product_sel, where sel is a round-robin counter over 0..N-1 (N = neuron fan-in).
  - This gives a scaled sum, (1/N)·Σ.
  - Layer 1 and layer 2 each have one shared select counter.
- Datapath is combinational from generator state to integrator input. Each integrator is an 8-bit counter.
- FSM:
  - IDLE:
    - in_ready = 1.
    - Weight writes are accepted here only; a write takes effect on the next clock.
    - Writes with out-of-range indices are ignored.
    - On in_valid & in_ready: latch in_data, go to LOAD.
  - LOAD (1 cycle):
    - Reload every LFSR with its seed.
    - Clear select counters, integrators and the cycle counter.
  - RUN:
    - Each cycle: integrator += output bit, LFSRs step, select counters advance and wrap N-1 to 0, cycle counter increments.
    - After STREAM_LEN cycles, copy integrators to out_data, set out_valid, go to DONE.
  - DONE:
    - out_valid and out_data are held stable until out_ready is sampled high.
    - Then clear out_valid and go to IDLE; out_data keeps its last value.
- wr_en outside IDLE: ignored; weights are unchanged.
- Simultaneous wr_en and in_valid in IDLE: the write completes in that cycle and the run uses the new weight.
- Latency: in_valid accepted at cycle t; out_valid asserted at t+2+STREAM_LEN.
- Counts never exceed STREAM_LEN (at most 255), so no overflow is possible.

Decomposition:
- Package bsn_pkg:
  - VALUE_W=8.
  - LFSR tap mask 8'hB8.
  - Function seed_of(base, idx).
  - State enum {IDLE, LOAD, RUN, DONE}.
- Sub-module bsn_generator: LFSR, seed load and comparator. It is instantiated for every input and every weight.
- Neurons, integrators and the FSM live in bsn_network.

Test Plan:
- Reset with all weights 0, run with inputs {255,255}: out_data=0; out_valid rises exactly 257 cycles after acceptance.
- All weights 255, inputs {255,255}: out_data=255.
- All weights 255, inputs {255,0}:
  - Both hidden streams alternate 1,0 starting with 1 at RUN cycle 0.
  - Output selects index 0 on even cycles, so out_data=128.
- Run the same input twice with back-to-back transactions: identical out_data both times. Hold out_ready low for 10 cycles: out_valid and out_data stay stable, in_ready stays 0.
- Weight write during RUN, then a rerun: result equals the pre-write result. Write in IDLE with an out-of-range wr_neuron=5: no weight changes.
- Assert rst at RUN cycle 100: out_valid=0, busy=0 immediately, weights=0. The next run with weights 0 gives out_data=0.
